// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
// Types and helpers shared by the adder tree `sum` and its feeder
// `sum_collect`.
//   sum_collect_state_t : collector FSM states (FILL while gathering, FULL
//                         while a complete vector waits for the consumer)
//   sum_lvl_w()         : width of a 0..2**n occupancy counter
// -----------------------------------------------------------------------------
package sum_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } sum_collect_state_t;

    // A counter that must hold 2**n needs one more bit than log2 of the word count.
    function automatic int sum_lvl_w(input int n);
        return n + 32'sd1;
    endfunction

endpackage

// File: rtl/sum_collect_if.sv
// -----------------------------------------------------------------------------
// sum_collect_if
// Handshake bundle between a sample producer / vector consumer (master) and
// the sum_collect block (slave).
//   in_vld, in_dat, in_rdy : serial sample stream into the collector
//   flush                  : synchronous pulse that discards the partial vector
//   out_vld, out_rdy       : vector handshake toward `sum`
//   out_dat                : packed [2**N-1:0][W-1:0] vector, index 0 = oldest
//   level                  : samples currently held (0 .. 2**N)
// -----------------------------------------------------------------------------
interface sum_collect_if
    import sum_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
);
    logic                          in_vld;
    logic [W-1:0]                  in_dat;
    logic                          in_rdy;
    logic                          flush;
    logic                          out_vld;
    logic                          out_rdy;
    logic [2**N-1:0][W-1:0]        out_dat;
    logic [sum_lvl_w(N)-1:0]       level;

    modport master (
        output in_vld, in_dat, flush, out_rdy,
        input  in_rdy, out_vld, out_dat, level
    );

    modport slave (
        input  in_vld, in_dat, flush, out_rdy,
        output in_rdy, out_vld, out_dat, level
    );
endinterface

// File: rtl/sum_collect.sv
// -----------------------------------------------------------------------------
// sum_collect
// Gathers a serial stream of W-bit samples into a packed vector of 2**N words
// for the adder tree `sum`, presented with a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : sum_collect_if.slave (in_vld/in_dat/in_rdy, flush,
//          out_vld/out_rdy/out_dat, level)
// Configuration:
//   SUM_COLLECT_SLIDE_EN undefined : block mode, one vector per 2**N samples.
//   SUM_COLLECT_SLIDE_EN defined   : sliding window, every accepted sample
//                                    shifts the window; one vector per sample
//                                    once the window is primed.
// All outputs are registered except in_rdy, which is combinational so a full
// vector and a new sample can be exchanged in the same cycle.
// -----------------------------------------------------------------------------
module sum_collect
    import sum_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    sum_collect_if.slave  bus
);

    localparam int NW = 2**N;
    localparam int LW = sum_lvl_w(N);

    typedef logic [NW-1:0][W-1:0] vec_t;

    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_LAST = LW'(NW - 1);
    localparam vec_t          VEC_ZERO = {(NW*W){1'b0}};

    sum_collect_state_t state_q, state_d;
    logic [LW-1:0]      level_q, level_d;
    logic               out_vld_q, out_vld_d;
    vec_t               out_dat_q, out_dat_d;

    logic               in_rdy_s;
    logic               in_acc_s;
    logic               out_acc_s;

    assign in_rdy_s  = ~out_vld_q | bus.out_rdy;
    assign in_acc_s  = bus.in_vld & in_rdy_s;
    assign out_acc_s = out_vld_q & bus.out_rdy;

    // Next-state computation for FSM, occupancy counter and vector datapath.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        if (bus.flush) begin
            // Flush overrides any transfer on the same edge; data words are kept.
            state_d   = FILL;
            level_d   = LVL_ZERO;
            out_vld_d = 1'b0;
        end else begin
`ifdef SUM_COLLECT_SLIDE_EN
            if (in_acc_s) begin
                for (int i = 0; i < NW - 1; i++) begin
                    out_dat_d[i] = out_dat_q[i+1];
                end
                out_dat_d[NW-1] = bus.in_dat;
                // Reaching or already at a full window: present it next cycle.
                if (level_q >= LVL_LAST) begin
                    level_d   = LW'(NW);
                    out_vld_d = 1'b1;
                    state_d   = FULL;
                end else begin
                    level_d   = level_q + LVL_ONE;
                    out_vld_d = 1'b0;
                    state_d   = FILL;
                end
            end else if (out_acc_s) begin
                out_vld_d = 1'b0;
            end else begin
                out_vld_d = out_vld_q;
            end
`else
            case (state_q)
                FILL: begin
                    if (in_acc_s) begin
                        // level is below 2**N here, so its low bits are the slot.
                        out_dat_d[level_q[N-1:0]] = bus.in_dat;
                        level_d                   = level_q + LVL_ONE;
                        if (level_q == LVL_LAST) begin
                            state_d   = FULL;
                            out_vld_d = 1'b1;
                        end else begin
                            state_d   = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                FULL: begin
                    // in_rdy is low unless out_rdy is high, so a sample can only
                    // arrive together with the consumer taking the vector.
                    if (out_acc_s) begin
                        state_d   = FILL;
                        out_vld_d = 1'b0;
                        if (in_acc_s) begin
                            out_dat_d[0] = bus.in_dat;
                            level_d      = LVL_ONE;
                        end else begin
                            level_d      = LVL_ZERO;
                        end
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d   = FILL;
                    level_d   = LVL_ZERO;
                    out_vld_d = 1'b0;
                end
            endcase
`endif
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            level_q   <= LVL_ZERO;
            out_vld_q <= 1'b0;
            out_dat_q <= VEC_ZERO;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign bus.in_rdy  = in_rdy_s;
    assign bus.out_vld = out_vld_q;
    assign bus.out_dat = out_dat_q;
    assign bus.level   = level_q;

endmodule

// File: tb/tb_sum_collect.sv
// -----------------------------------------------------------------------------
// tb_sum_collect
// Directed and randomized stimulus for sum_collect (W=8, N=2 -> 4 words),
// checked against a queue-based reference model of the collector.
// -----------------------------------------------------------------------------
module tb_sum_collect;

    logic clk;
    logic rst;

    sum_collect_if #(.W(8), .N(2)) bus ();

    sum_collect #(.W(8), .N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          exp_vld;
    logic [7:0]  part[$];     // block mode: samples of the vector being gathered
    logic [7:0]  hist[$];     // sliding mode: the last four samples, oldest first
    int          cnt;         // sliding mode: samples in window (saturating)
    logic [31:0] exp_vec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_level();
`ifdef SUM_COLLECT_SLIDE_EN
        return cnt;
`else
        return exp_vld ? 4 : part.size();
`endif
    endfunction

    task automatic model_reset();
        exp_vld = 1'b0;
        part.delete();
        hist = '{8'd0, 8'd0, 8'd0, 8'd0};
        cnt = 0;
        exp_vec = 32'd0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"}, 32'(bus.out_vld), 32'(exp_vld));
        chk({tag, "_level"}, 32'(bus.level), 32'(exp_level()));
`ifdef SUM_COLLECT_SLIDE_EN
        chk({tag, "_dat"}, bus.out_dat, exp_vec);
`else
        if (exp_vld) chk({tag, "_dat"}, bus.out_dat, exp_vec);
        else         n_tests = n_tests;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_vld = 1'b0; bus.in_dat = 8'd0; bus.out_rdy = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("rst_dat", bus.out_dat, 32'd0);
        rst = 1'b0;
    endtask

    // One clock cycle: drive, check in_rdy, advance model at the edge, check outputs.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r, input bit f);
        bit e_rdy, ia, oa;
        bus.in_vld = v; bus.in_dat = d; bus.out_rdy = r; bus.flush = f;
        #1;
        e_rdy = !exp_vld || r;
        chk("in_rdy", 32'(bus.in_rdy), 32'(e_rdy));
        ia = v && e_rdy;
        oa = exp_vld && r;
        @(posedge clk);
        if (f) begin
            exp_vld = 1'b0;
            part.delete();
            cnt = 0;
        end else begin
`ifdef SUM_COLLECT_SLIDE_EN
            if (ia) begin
                void'(hist.pop_front());
                hist.push_back(d);
                exp_vld = (cnt + 1 >= 4);
                if (cnt < 4) cnt++;
            end else if (oa) begin
                exp_vld = 1'b0;
            end
`else
            if (oa) exp_vld = 1'b0;
            if (ia) begin
                part.push_back(d);
                if (part.size() == 4) begin
                    exp_vec = {part[3], part[2], part[1], part[0]};
                    exp_vld = 1'b1;
                    part.delete();
                end
            end
`endif
        end
`ifdef SUM_COLLECT_SLIDE_EN
        exp_vec = {hist[3], hist[2], hist[1], hist[0]};
`endif
        #1;
        check_outputs("cyc");
    endtask

    initial begin
        rst = 1'b1;
        bus.in_vld = 1'b0; bus.in_dat = 8'd0; bus.out_rdy = 1'b0; bus.flush = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

`ifdef SUM_COLLECT_SLIDE_EN
        // Sliding window over 1..6
        for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("slide_last_win", bus.out_dat, 32'h06050403);
        chk("slide_level", 32'(bus.level), 32'd4);
        // flush empties the window but keeps the data words
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        chk("slide_flush_dat", bus.out_dat, 32'h06050403);
        chk("slide_flush_level", 32'(bus.level), 32'd0);
`else
        // Four samples back to back
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("t2_vld", 32'(bus.out_vld), 32'd1);
        chk("t2_vec", bus.out_dat, 32'h04030201);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // Backpressure for 3 cycles, then exchange with sample 9
        for (int i = 5; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hAA, 1'b0, 1'b0);
            chk("t3_hold", bus.out_dat, 32'h08070605);
        end
        cyc(1'b1, 8'd9, 1'b1, 1'b0);
        chk("t3_level", 32'(bus.level), 32'd1);
        chk("t3_word0", 32'(bus.out_dat[0]), 32'd9);
        for (int i = 10; i <= 12; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("t3_vec", bus.out_dat, 32'h0c0b0a09);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // flush mid-vector
        cyc(1'b1, 8'd1, 1'b1, 1'b0);
        cyc(1'b1, 8'd2, 1'b1, 1'b0);
        cyc(1'b1, 8'd77, 1'b1, 1'b1);
        for (int i = 3; i <= 6; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        chk("t4_vec", bus.out_dat, 32'h06050403);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);

        // reset mid-vector
        for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 10), 1'b1, 1'b0);
        chk("t5_vec", bus.out_dat, 32'h281e140a);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
`endif

        // Randomized traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
